// File: rtl/uart_wb_host_bridge_if.sv
// Wishbone classic master port and tx/rx byte streams of the UART host bridge.
// Signal names keep the bridge-side direction suffixes for both modports.
interface uart_wb_host_bridge_if;
    logic [4:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_ack_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       init_done_o;
    logic       err_timeout_o;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output tx_ready_o, rx_data_o, rx_valid_o, init_done_o, err_timeout_o,
        input  wb_dat_i, wb_ack_i, tx_data_i, tx_valid_i, rx_ready_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  tx_ready_o, rx_data_o, rx_valid_o, init_done_o, err_timeout_o,
        output wb_dat_i, wb_ack_i, tx_data_i, tx_valid_i, rx_ready_i
    );
endinterface

// File: rtl/uart_wb_host_bridge.sv
// Wishbone classic master that initialises a 16550 UART and then polls LSR to move
// bytes between single-entry tx/rx stream buffers and THR/RBR.
module uart_wb_host_bridge #(
    parameter logic [15:0] DIVISOR     = 16'd27,
    parameter logic [7:0]  LCR_VAL     = 8'h03,
    parameter logic [7:0]  FCR_VAL     = 8'h07,
    parameter int unsigned POLL_GAP    = 8,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input logic                   wb_clk_i,
    input logic                   wb_rst_i,
    uart_wb_host_bridge_if.master bus
);
    localparam logic [4:0] AdrData = 5'd0;
    localparam logic [4:0] AdrDlm  = 5'd1;
    localparam logic [4:0] AdrFcr  = 5'd2;
    localparam logic [4:0] AdrLcr  = 5'd3;
    localparam logic [4:0] AdrLsr  = 5'd5;

    localparam int unsigned GapW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam int unsigned ToW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(POLL_GAP);
    localparam logic [ToW-1:0]  ToLast  = ToW'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StInit0, StInit1, StInit2, StInit3, StInit4,
        StIdle, StPollLsr, StRdRbr, StWrThr, StHalt
    } state_e;

    state_e          state_q;
    logic [4:0]      adr_q;
    logic [7:0]      dat_q;
    logic            we_q;
    logic            cyc_q;
    logic [7:0]      tx_buf_q;
    logic            tx_full_q;
    logic [7:0]      rx_data_q;
    logic            rx_full_q;
    logic            init_done_q;
    logic            err_q;
    logic [GapW-1:0] gap_q;
    logic [ToW-1:0]  to_q;

    logic [4:0] req_adr;
    logic [7:0] req_dat;
    logic       req_we;
    logic       req_valid;
    logic       tx_ready;
    logic       init_phase;

    assign tx_ready   = init_done_q & ~tx_full_q;
    assign init_phase = state_q inside {StInit0, StInit1, StInit2, StInit3, StInit4};

    // Bus request belonging to each state; issued once on entry, held until ack/timeout.
    always_comb begin
        req_adr   = AdrData;
        req_dat   = 8'h00;
        req_we    = 1'b0;
        req_valid = 1'b1;
        unique case (state_q)
            StInit0:   begin req_adr = AdrLcr;  req_dat = 8'h80 | LCR_VAL; req_we = 1'b1; end
            StInit1:   begin req_adr = AdrData; req_dat = DIVISOR[7:0];    req_we = 1'b1; end
            StInit2:   begin req_adr = AdrDlm;  req_dat = DIVISOR[15:8];   req_we = 1'b1; end
            StInit3:   begin req_adr = AdrLcr;  req_dat = LCR_VAL;         req_we = 1'b1; end
            StInit4:   begin req_adr = AdrFcr;  req_dat = FCR_VAL;         req_we = 1'b1; end
            StPollLsr: req_adr = AdrLsr;
            StRdRbr:   req_adr = AdrData;
            StWrThr:   begin req_adr = AdrData; req_dat = tx_buf_q;        req_we = 1'b1; end
            default:   req_valid = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= StInit0;
            adr_q       <= 5'd0;
            dat_q       <= 8'h00;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            tx_buf_q    <= 8'h00;
            tx_full_q   <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_full_q   <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            gap_q       <= '0;
            to_q        <= '0;
        end else begin
            if (bus.tx_valid_i && tx_ready) begin
                tx_buf_q  <= bus.tx_data_i;
                tx_full_q <= 1'b1;
            end
            if (rx_full_q && bus.rx_ready_i) begin
                rx_full_q <= 1'b0;
            end

            if (cyc_q) begin
                if (bus.wb_ack_i) begin
                    cyc_q <= 1'b0;
                    we_q  <= 1'b0;
                    unique case (state_q)
                        StInit0: state_q <= StInit1;
                        StInit1: state_q <= StInit2;
                        StInit2: state_q <= StInit3;
                        StInit3: state_q <= StInit4;
                        StInit4: begin
                            state_q     <= StIdle;
                            init_done_q <= 1'b1;
                        end
                        StPollLsr: begin
                            // rx has priority; a full rx slot blocks RBR reads
                            if (bus.wb_dat_i[0] && !rx_full_q) begin
                                state_q <= StRdRbr;
                            end else if (bus.wb_dat_i[5] && tx_full_q) begin
                                state_q <= StWrThr;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                        StRdRbr: begin
                            rx_data_q <= bus.wb_dat_i;
                            rx_full_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                        StWrThr: begin
                            tx_full_q <= 1'b0;
                            state_q   <= StIdle;
                        end
                        default: state_q <= state_q;
                    endcase
                end else if (to_q == ToLast) begin
                    cyc_q <= 1'b0;
                    we_q  <= 1'b0;
                    err_q <= 1'b1;
                    if (init_phase) begin
                        state_q <= StHalt;
                    end else begin
                        state_q <= StIdle;
                    end
                    if (state_q == StWrThr) begin
                        tx_full_q <= 1'b0;
                    end
                end else begin
                    to_q <= to_q + ToW'(1);
                end
            end else if (req_valid) begin
                cyc_q <= 1'b1;
                adr_q <= req_adr;
                dat_q <= req_dat;
                we_q  <= req_we;
                to_q  <= '0;
            end else if (state_q == StIdle) begin
                if (gap_q == GapLast) begin
                    gap_q   <= '0;
                    state_q <= StPollLsr;
                end else begin
                    gap_q <= gap_q + GapW'(1);
                end
            end
        end
    end

    assign bus.wb_adr_o      = adr_q;
    assign bus.wb_dat_o      = dat_q;
    assign bus.wb_we_o       = we_q;
    assign bus.wb_cyc_o      = cyc_q;
    assign bus.wb_stb_o      = cyc_q;
    assign bus.tx_ready_o    = tx_ready;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.rx_valid_o    = rx_full_q;
    assign bus.init_done_o   = init_done_q;
    assign bus.err_timeout_o = err_q;
endmodule

// File: tb/tb_uart_wb_host_bridge.sv
// Bench for uart_wb_host_bridge: a Wishbone UART register model answers the bridge,
// a monitor logs acked transactions, and directed/random steps check them.
module tb_uart_wb_host_bridge;
    localparam int unsigned PollGap    = 8;
    localparam int unsigned AckTimeout = 64;
    localparam logic [4:0]  InitAdr[5] = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd2};
    localparam logic [7:0]  InitDat[5] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    uart_wb_host_bridge_if bus ();

    uart_wb_host_bridge #(
        .DIVISOR    (16'd27),
        .LCR_VAL    (8'h03),
        .FCR_VAL    (8'h07),
        .POLL_GAP   (PollGap),
        .ACK_TIMEOUT(AckTimeout)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] adr;
        logic       we;
        logic [7:0] dat;
        int         issue;
        int         ack;
    } xact_t;

    xact_t      log_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] lsr_val = 8'h00;
    logic [7:0] rbr_val = 8'h00;
    int         ack_lat = 1;
    logic       thr_noack = 1'b0;
    int         wcnt = 0;
    int         mon_cyc = 0;
    int         mon_issue = 0;
    int         mon_last_ack = -10;
    logic       mon_cyc_prev = 1'b0;
    logic       mon_ack_prev = 1'b0;
    logic [13:0] mon_req_prev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int find_xact(input int from, input logic [4:0] adr, input logic we);
        for (int i = from; i < log_q.size(); i++) begin
            if (log_q[i].adr == adr && log_q[i].we == we) return i;
        end
        return -1;
    endfunction

    // UART register model: LSR at 5, RBR at 0; THR writes can be left unacknowledged.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_ack_i <= 1'b0;
            bus.wb_dat_i <= 8'h00;
            wcnt         <= 0;
        end else begin
            bus.wb_ack_i <= 1'b0;
            if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i) begin
                if (thr_noack && bus.wb_we_o && bus.wb_adr_o == 5'd0) begin
                    wcnt <= 0;
                end else if (wcnt >= ack_lat) begin
                    bus.wb_ack_i <= 1'b1;
                    bus.wb_dat_i <= (bus.wb_adr_o == 5'd5) ? lsr_val : rbr_val;
                    wcnt         <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else begin
                wcnt <= 0;
            end
        end
    end

    // Monitor: logs acked transactions, checks hold-stable and one idle cycle between them.
    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (bus.wb_cyc_o) begin
                check("stb_eq_cyc", bus.wb_stb_o, 1);
                if (!mon_cyc_prev || mon_ack_prev) begin
                    mon_issue = mon_cyc;
                    check("idle_between", (mon_cyc - mon_last_ack) >= 2, 1);
                end else begin
                    check("hold_stable", {bus.wb_adr_o, bus.wb_we_o, bus.wb_dat_o},
                          mon_req_prev);
                end
                if (bus.wb_ack_i) begin
                    log_q.push_back('{bus.wb_adr_o, bus.wb_we_o,
                                      bus.wb_we_o ? bus.wb_dat_o : bus.wb_dat_i,
                                      mon_issue, mon_cyc});
                    mon_last_ack = mon_cyc;
                end
            end
            mon_cyc_prev = bus.wb_cyc_o;
            mon_ack_prev = bus.wb_cyc_o && bus.wb_ack_i;
            mon_req_prev = {bus.wb_adr_o, bus.wb_we_o, bus.wb_dat_o};
        end
    end

    task automatic check_init(input string tag);
        int k = 0;
        while (log_q.size() < 5 && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_count"}, log_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_q.size()) begin
                check($sformatf("%s_w%0d", tag, i),
                      {log_q[i].adr, log_q[i].we, log_q[i].dat},
                      {InitAdr[i], 1'b1, InitDat[i]});
            end
        end
        check({tag, "_done_at_ack"}, bus.init_done_o, 0);
        tick();
        check({tag, "_done_after"}, bus.init_done_o, 1);
        check({tag, "_tx_ready"}, bus.tx_ready_o, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        int k = 0;
        while (bus.tx_ready_o !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_ready_wait"}, bus.tx_ready_o, 1);
        bus.tx_data_i  = b;
        bus.tx_valid_i = 1'b1;
        tick();
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = 8'h00;
        check({tag, "_ready_drop"}, bus.tx_ready_o, 0);
    endtask

    // LSR reports THRE only: the byte must go out as one THR write right after an LSR read.
    task automatic run_tx(input logic [7:0] b, input string tag);
        int   k = 0;
        int   idx;
        int   mark;
        logic hold_ok = 1'b1;
        lsr_val = 8'h60;
        mark = log_q.size();
        send_byte(b, tag);
        while (find_xact(mark, 5'd0, 1'b1) < 0 && k < 400) begin
            if (bus.tx_ready_o !== 1'b0) hold_ok = 1'b0;
            tick();
            k++;
        end
        idx = find_xact(mark, 5'd0, 1'b1);
        check({tag, "_thr_seen"}, idx >= 0, 1);
        check({tag, "_ready_at_ack"}, bus.tx_ready_o, 0);
        check({tag, "_ready_held_low"}, hold_ok, 1);
        tick();
        check({tag, "_ready_back"}, bus.tx_ready_o, 1);
        if (idx > 0) begin
            check({tag, "_thr_data"}, log_q[idx].dat, b);
            check({tag, "_lsr_before"}, {log_q[idx-1].adr, log_q[idx-1].we}, {5'd5, 1'b0});
        end
        lsr_val = 8'h00;
    endtask

    // tx byte buffered, then LSR shows DR|THRE with rx_ready low: expect exactly RBR then THR.
    task automatic run_rx_tx(input logic [7:0] txb, input logic [7:0] rbr, input string tag);
        int    k = 0;
        int    mark;
        logic  seen = 1'b0;
        logic  stable = 1'b1;
        xact_t act[$];
        lsr_val = 8'h00;
        rbr_val = rbr;
        send_byte(txb, tag);
        mark = log_q.size();
        lsr_val = 8'h61;
        while (find_xact(mark, 5'd0, 1'b1) < 0 && k < 800) begin
            if (seen && (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== rbr)) stable = 1'b0;
            if (bus.rx_valid_o === 1'b1) seen = 1'b1;
            tick();
            k++;
        end
        lsr_val = 8'h00;
        check({tag, "_thr_seen"}, find_xact(mark, 5'd0, 1'b1) >= 0, 1);
        check({tag, "_rx_valid"}, bus.rx_valid_o, 1);
        check({tag, "_rx_data"}, bus.rx_data_o, rbr);
        check({tag, "_rx_stable"}, stable, 1);
        for (int i = mark; i < log_q.size(); i++) begin
            if (!(log_q[i].adr == 5'd5 && !log_q[i].we)) act.push_back(log_q[i]);
        end
        check({tag, "_access_count"}, act.size(), 2);
        if (act.size() >= 2) begin
            check({tag, "_first_rbr"}, {act[0].adr, act[0].we, act[0].dat}, {5'd0, 1'b0, rbr});
            check({tag, "_then_thr"}, {act[1].adr, act[1].we, act[1].dat}, {5'd0, 1'b1, txb});
        end
        bus.rx_ready_i = 1'b1;
        tick();
        bus.rx_ready_i = 1'b0;
        check({tag, "_rx_popped"}, bus.rx_valid_o, 0);
    endtask

    initial begin
        int         k;
        int         mark;
        int         n_bad;
        int         min_gap;
        logic [7:0] b1;
        logic [7:0] b2;

        bus.tx_data_i  = 8'h00;
        bus.tx_valid_i = 1'b0;
        bus.rx_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_bus", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o}, 0);
        check("rst_flags", {bus.tx_ready_o, bus.rx_valid_o, bus.init_done_o, bus.err_timeout_o}, 0);
        check("rst_rx_data", bus.rx_data_o, 0);
        rst_n = 1'b1;
        check_init("init");

        run_tx(8'h55, "tx55");
        b1 = 8'($urandom_range(0, 255));
        run_rx_tx(b1, 8'hA7, "rxA7");

        for (int i = 0; i < 4; i++) begin
            ack_lat = $urandom_range(0, 3);
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            run_rx_tx(b1, b2, $sformatf("rnd%0d", i));
            b1 = 8'($urandom_range(0, 255));
            run_tx(b1, $sformatf("rndtx%0d", i));
        end

        // Ten idle polls: only LSR reads, each issued at least PollGap+1 cycles after the last ack.
        ack_lat = 1;
        lsr_val = 8'h00;
        mark = log_q.size();
        k = 0;
        while (log_q.size() < mark + 11 && k < 600) begin
            tick();
            k++;
        end
        check("poll_count", log_q.size() >= mark + 11, 1);
        n_bad = 0;
        min_gap = 1000;
        for (int i = mark + 1; i < log_q.size(); i++) begin
            if (log_q[i].adr != 5'd5 || log_q[i].we) n_bad++;
            if (log_q[i].issue - log_q[i-1].ack < min_gap) min_gap = log_q[i].issue - log_q[i-1].ack;
        end
        check("poll_only_lsr", n_bad, 0);
        check("poll_gap_min", min_gap >= int'(PollGap) + 1, 1);

        // THR write never acknowledged: cycle must be abandoned after AckTimeout cycles.
        lsr_val = 8'h60;
        thr_noack = 1'b1;
        b1 = 8'($urandom_range(0, 255));
        send_byte(b1, "to");
        k = 0;
        while (!(bus.wb_cyc_o && bus.wb_we_o && bus.wb_adr_o == 5'd0) && k < 300) begin
            tick();
            k++;
        end
        check("to_thr_issued", bus.wb_cyc_o, 1);
        k = 0;
        while (bus.wb_cyc_o && k < 200) begin
            tick();
            k++;
        end
        check("to_cycle_len", k, AckTimeout);
        check("to_stb_low", bus.wb_stb_o, 0);
        check("to_err", bus.err_timeout_o, 1);
        check("to_ready", bus.tx_ready_o, 1);
        thr_noack = 1'b0;
        b2 = 8'($urandom_range(0, 255));
        run_tx(b2, "after_to");
        check("to_err_sticky", bus.err_timeout_o, 1);

        // Reset during INIT2 drops the bus at once; init restarts from the first write.
        rst_n = 1'b0;
        tick();
        check("rst2_err_clear", bus.err_timeout_o, 0);
        check("rst2_done_clear", bus.init_done_o, 0);
        log_q.delete();
        ack_lat = 3;
        rst_n = 1'b1;
        k = 0;
        while (!(bus.wb_cyc_o && bus.wb_we_o && bus.wb_adr_o == 5'd1) && k < 200) begin
            tick();
            k++;
        end
        check("rst2_in_init2", bus.wb_cyc_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst2_async_cyc", bus.wb_cyc_o, 0);
        check("rst2_async_stb", bus.wb_stb_o, 0);
        tick();
        log_q.delete();
        rst_n = 1'b1;
        check_init("reinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_wb_host_bridge.md
Name: uart_wb_host_bridge

Overview:
- Wishbone classic master that sits directly upstream of the 16550 UART core and drives its Wishbone slave port.
- After reset, it programs the UART: divisor latch, 8N1 line control, and FIFO enable.
- It then polls LSR and moves bytes in both directions:
  - TX: a valid/ready byte stream is written into THR.
  - RX: RBR contents are returned on a valid/ready byte stream.
- Gives SoC logic and the UART bench a byte-stream front end without hand-written register accesses.

Parameters:
- DIVISOR, 16'd27: baud divisor written to DLL/DLM.
- LCR_VAL, 8'h03: line control after init (8 data bits, no parity, 1 stop).
- FCR_VAL, 8'h07: FIFO control written at init (enable, clear RX/TX FIFOs).
- POLL_GAP, 8: idle cycles between consecutive LSR polls; 0 means back-to-back.
- ACK_TIMEOUT, 64: cycles to wait for wb_ack_i before aborting a cycle.

Ports:
- wb_clk_i, in, 1: clock.
- wb_rst_i, in, 1: reset, asynchronous, active-low.
- wb_adr_o, out, 5: UART register address.
- wb_dat_o, out, 8: write data.
- wb_dat_i, in, 8: read data.
- wb_we_o, out, 1: write enable.
- wb_cyc_o, out, 1: bus cycle.
- wb_stb_o, out, 1: strobe.
- wb_ack_i, in, 1: slave acknowledge.
- tx_data_i, in, 8: byte to transmit.
- tx_valid_i, in, 1: tx byte valid.
- tx_ready_o, out, 1: bridge can accept a tx byte.
- rx_data_o, out, 8: received byte.
- rx_valid_o, out, 1: rx byte valid.
- rx_ready_i, in, 1: consumer accepts rx byte.
- init_done_o, out, 1: init sequence complete.
- err_timeout_o, out, 1: sticky ack-timeout flag.

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - All outputs go to 0; state goes to INIT0; tx buffer and rx slot go empty; counters go to 0.
  - Reset mid-transaction drops cyc/stb immediately; no transaction is completed.
- Bus protocol (classic single cycle):
  - In the issue cycle, assert cyc=stb=1 with adr/we/dat; hold all of them stable until the first cycle with wb_ack_i=1.
  - The cycle after ack, cyc=stb=we=0.
  - Read data is sampled on the ack cycle.
  - At most one transaction is outstanding; there are no back-to-back cycles without one idle cycle.
- Init sequence, one write each, in order:
  - INIT0: adr 3 = 8'h80 | LCR_VAL.
  - INIT1: adr 0 = DIVISOR[7:0].
  - INIT2: adr 1 = DIVISOR[15:8].
  - INIT3: adr 3 = LCR_VAL.
  - INIT4: adr 2 = FCR_VAL.
  - Then IDLE; init_done_o goes to 1 the cycle after the INIT4 ack and stays 1 until reset.
- TX buffer (1 entry):
  - tx_ready_o = init_done_o & tx buffer empty.
  - The byte is captured when tx_valid_i & tx_ready_o.
  - tx_ready_o drops the next cycle.
- RX slot (1 entry):
  - rx_valid_o = slot full.
  - The slot clears when rx_valid_i... handshake: when rx_valid_o & rx_ready_i.
  - rx_data_o is stable while rx_valid_o=1.
- States:
  - IDLE: the gap counter counts POLL_GAP cycles, then goes to POLL_LSR.
  - POLL_LSR: read adr 5 (LSR).
  - Decide, rx first: if LSR[0] (DR) and the rx slot is empty, go to RD_RBR. Else if LSR[5] (THRE) and the tx buffer is full, go to WR_THR. Else go to IDLE.
  - RD_RBR: read adr 0. On ack, load the rx slot, then IDLE.
  - WR_THR: write adr 0 with the buffered byte. On ack, empty the tx buffer, then IDLE.
  - One THR write per LSR poll; the UART TX FIFO is never overrun.
- Simultaneous events:
  - A tx capture in the same cycle as a WR_THR ack cannot occur, because tx_ready_o=0 while the buffer is full.
  - An rx slot pop in the same cycle as an RD_RBR ack cannot occur, because RD_RBR is only entered with the slot empty.
- Ack timeout:
  - The counter starts at issue and resets per transaction.
  - After ACK_TIMEOUT cycles without ack: drop cyc/stb and set err_timeout_o=1 (sticky until reset).
  - During init: enter HALT, where there is no further bus activity, init_done_o=0, and tx_ready_o=0.
  - During WR_THR: discard the tx byte, then IDLE.
  - During POLL/RD: no rx byte is produced, then IDLE.
- An ack outside an active cycle is ignored.

Test Plan:
- Reset release, slave acks after 2 cycles:
  - Required: exactly 5 writes, in order (3,0x83), (0,0x1B), (1,0x00), (3,0x03), (2,0x07).
  - Required: init_done_o=1 one cycle after the 5th ack.
  - Required: tx_ready_o=1 at the same time.
- After init, send tx_data_i=0x55 with the LSR model returning 0x60:
  - Required: an LSR read, then a write (adr 0, dat 0x55).
  - Required: tx_ready_o=0 from the capture until the cycle after the THR ack.
  - Bench check: the serial tx line carries 0x55 at 8N1.
- LSR returns 0x61, RBR=0xA7, tx buffer full, rx_ready_i=0:
  - Required: RBR is read first.
  - Required: rx_valid_o=1 with rx_data_o=0xA7, held stable.
  - Required: the next poll skips RBR even with DR=1, and THR is written.
- LSR stays 0x00 for 10 polls with POLL_GAP=8:
  - Required: each LSR read starts at least 9 cycles after the previous ack.
  - Required: no THR or RBR accesses.
- Slave never acks during WR_THR:
  - Required: cyc/stb drop after 64 cycles and err_timeout_o=1.
  - Required: tx_ready_o=1 again, and the next tx byte is processed normally.
- Assert wb_rst_i=0 mid INIT2, then release:
  - Required: cyc/stb=0 asynchronously.
  - Required: after release, init restarts from INIT0 with the full 5-write sequence.
